keypad_display_ctrl: RTL
========================

// Module: keypad_display_ctrl
// PURPOSE
//  Scans a 4x4 matrix keypad, debounces, and commits one hex code per physical press.
//  Keeps the last two codes; the newest shows on the right digit, the previous on the left.
//  Time-multiplexes the single seven-segment decoder between the two common-anode digits.
//  Sits between the keypad pins and the hex-to-segment decoder in the lab3 top level.
// PARAMETERS
//  SCAN_DIV      24000   int_osc cycles each column is driven (>=2)
//  DEBOUNCE_CYC  240000  cycles of stable level required for press and for release (>=1)
//  MUX_DIV       48000   int_osc cycles per display digit phase (>=2)
// PORTS
//  int_osc   in   1  system clock; the only clock
//  reset     in   1  synchronous, active-high reset
//  row       in   4  keypad rows, active-high (board pull-downs)
//  col       out  4  keypad column drive, one-hot, active-high
//  hex_sel   out  4  code to the seven-segment decoder for the active digit
//  an        out  2  digit enables, active-low; an[0]=right/new, an[1]=left/old
//  key_valid out  1  one-cycle pulse when a new code is committed
// BEHAVIOUR
//  Reset values: col=4'b0001, digit_new=digit_old=4'h0, hex_sel=4'h0, an=2'b10,
//   key_valid=0, FSM=SCAN, all counters=0.
//  Reset taken mid-operation behaves the same; no held key is committed afterwards until released and re-pressed.
//  rows_s = rows as sampled by the FSM (see CONFIGURATION).
//  FSM states: SCAN, DEBOUNCE, COMMIT, HELD, RELEASE.
//  SCAN:
//   - col rotates 0001->0010->0100->1000->0001, advancing every SCAN_DIV cycles.
//   - rows_s is sampled only on the last dwell cycle (scan_cnt==SCAN_DIV-1).
//   - Exactly one row high: latch row/col index, freeze col, go to DEBOUNCE.
//   - Zero rows or more than one row high: advance col and stay in SCAN.
//  DEBOUNCE:
//   - cnt increments while the latched row stays high.
//   - Latched row low: cnt=0, go to SCAN, col advances.
//   - At cnt==DEBOUNCE_CYC-1: go to COMMIT.
//  COMMIT (1 cycle): digit_old<=digit_new, digit_new<=keymap(row,col), key_valid=1; then HELD.
//  HELD:
//   - col stays frozen; other keys are ignored.
//   - Latched row low: cnt=0, go to RELEASE.
//  RELEASE:
//   - cnt increments while the latched row stays low; latched row high restarts cnt=0 and no new commit occurs.
//   - At cnt==DEBOUNCE_CYC-1: go to SCAN, col advances.
//  Keymap (row0..3 top-bottom, col0..3 left-right): 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
//  Display mux:
//   - Free-running mux_cnt wraps at MUX_DIV-1; phase toggles at each wrap.
//   - phase 0: hex_sel=digit_new, an=2'b10; phase 1: hex_sel=digit_old, an=2'b01.
//   - Blanking: an=2'b11 on the last cycle of each phase (mux_cnt==MUX_DIV-1).
//   - hex_sel is registered and updates one cycle after digit changes.
//  Latency: commit happens DEBOUNCE_CYC+1 cycles after the detecting sample, plus sync delay.
// CONFIGURATION
//  KEYPAD_SYNC_EN defined:
//   - row passes through a 2-flop synchronizer and rows_s is the synchronized value.
//   - All detection is delayed by 2 cycles; the sample point for each column still sits at the end of its dwell.
//   - The sync flops reset to 0.
//  KEYPAD_SYNC_EN undefined: rows_s is row sampled directly.
// STRUCTURE
//  keypad_pkg:
//   - state_t enum.
//   - keymap function (row idx, col idx) -> logic [3:0].
//   - Constants NROW=4, NCOL=4.
//  Sub-module keypad_display_mux: mux counter, phase, an, hex_sel; inputs digit_new/digit_old.
//  Top level holds the scan/debounce FSM, counters, digit registers and the optional synchronizer.
// TESTING (SCAN_DIV=4, DEBOUNCE_CYC=8, MUX_DIV=4)
//  1. Hold reset 2 cycles -> col=0001, an=2'b10, hex_sel=0, key_valid=0.
//  2. Hold row=0001 whenever col=0010 (key "2") ->
//     - key_valid pulses once, 9 cycles after the detecting sample.
//     - digit_new=2, digit_old=0.
//     - Holding the key for 200 cycles produces no further pulse.
//  3. Press "2", release, then press "D" (row3,col3) -> digit_new=D, digit_old=2; hex_sel alternates D/2 each 4 cycles.
//  4. Bounce: row high 3 cycles, low 1 cycle, repeated -> no key_valid; scanning resumes.
//  5. Multi-row: row=0011 while col=0001 -> no commit, col advances.
//     During HELD on "5", press "9" -> ignored.
//  6. Assert reset while in HELD -> outputs return to reset values.
//     With the key still held, no commit occurs until release and re-press.
//     With KEYPAD_SYNC_EN, check the extra 2-cycle latency.

Source files
------------

// File: rtl/keypad_pkg.sv
//------------------------------------------------------------------------------
// Module : keypad_pkg
// Brief  : Shared types, dimensions and key-code map for the keypad controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

  localparam int NROW = 4;
  localparam int NCOL = 4;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    COMMIT   = 3'd2,
    HELD     = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  // Rows top-to-bottom, columns left-to-right: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_display_mux.sv
//------------------------------------------------------------------------------
// Module : keypad_display_mux
// Brief  : Time-multiplexes one hex code between two common-anode digits.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypad_display_mux
  import keypad_pkg::*;
#(
  parameter int MUX_DIV = 48000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_new,
  input  logic [3:0] digit_old,
  output logic [3:0] hex_sel,
  output logic [1:0] an
);

  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);

  logic [MW-1:0] mux_cnt_q, mux_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    hex_sel_q, hex_sel_d;
  logic [1:0]    an_q, an_d;

  // Outputs are computed from next-state values so they stay aligned with mux_cnt_q.
  always_comb begin
    mux_cnt_d = mux_cnt_q + MW'(1);
    phase_d   = phase_q;
    if (mux_cnt_q == MUX_LAST) begin
      mux_cnt_d = '0;
      phase_d   = ~phase_q;
    end
    hex_sel_d = phase_d ? digit_old : digit_new;
    an_d      = phase_d ? 2'b01 : 2'b10;
    if (mux_cnt_d == MUX_LAST) an_d = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_cnt_q <= '0;
      phase_q   <= 1'b0;
      hex_sel_q <= 4'h0;
      an_q      <= 2'b10;
    end else begin
      mux_cnt_q <= mux_cnt_d;
      phase_q   <= phase_d;
      hex_sel_q <= hex_sel_d;
      an_q      <= an_d;
    end
  end

  assign hex_sel = hex_sel_q;
  assign an      = an_q;

endmodule

`default_nettype wire

// File: rtl/keypad_display_ctrl.sv
//------------------------------------------------------------------------------
// Module : keypad_display_ctrl
// Brief  : 4x4 keypad scan/debounce FSM with two-digit display; KEYPAD_SYNC_EN
//          adds a 2-flop row synchronizer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypad_display_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 24000,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int MUX_DIV      = 48000
) (
  input  logic            int_osc,
  input  logic            reset,
  input  logic [NROW-1:0] row,
  output logic [NCOL-1:0] col,
  output logic [3:0]      hex_sel,
  output logic [1:0]      an,
  output logic            key_valid
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

  logic [NROW-1:0] rows_s;

`ifdef KEYPAD_SYNC_EN
  logic [NROW-1:0] sync1_q, sync2_q;
  always_ff @(posedge int_osc) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end
  assign rows_s = sync2_q;
`else
  assign rows_s = row;
`endif

  state_t          state_q, state_d;
  logic [NCOL-1:0] col_q, col_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [3:0]      digit_new_q, digit_new_d;
  logic [3:0]      digit_old_q, digit_old_d;
  logic            key_valid_q, key_valid_d;
  logic            armed_q, armed_d;
  logic [1:0]      clean_cnt_q, clean_cnt_d;
  logic [1:0]      det_row;
  logic            latched_hi;

  always_comb begin
    case (rows_s)
      4'b0001: det_row = 2'd0;
      4'b0010: det_row = 2'd1;
      4'b0100: det_row = 2'd2;
      default: det_row = 2'd3;
    endcase
    latched_hi = rows_s[row_idx_q];
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    scan_cnt_d  = scan_cnt_q;
    cnt_d       = cnt_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    key_valid_d = 1'b0;
    armed_d     = armed_q;
    clean_cnt_d = clean_cnt_q;
    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          // A key still down across reset is ignored until one full empty sweep.
          if (rows_s == '0) begin
            if (clean_cnt_q == 2'd3) armed_d = 1'b1;
            else clean_cnt_d = clean_cnt_q + 2'd1;
          end else begin
            clean_cnt_d = 2'd0;
          end
          if (armed_q && $onehot(rows_s)) begin
            row_idx_d = det_row;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d     = {col_q[NCOL-2:0], col_q[NCOL-1]};
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (!latched_hi) begin
          cnt_d     = '0;
          state_d   = SCAN;
          col_d     = {col_q[NCOL-2:0], col_q[NCOL-1]};
          col_idx_d = col_idx_q + 2'd1;
        end else if (cnt_q == DEB_LAST) begin
          // Digits and key_valid load on the edge into COMMIT so both show during COMMIT.
          cnt_d       = '0;
          state_d     = COMMIT;
          digit_old_d = digit_new_q;
          digit_new_d = keymap(row_idx_q, col_idx_q);
          key_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      COMMIT: state_d = HELD;
      HELD: begin
        if (!latched_hi) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (latched_hi) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d     = '0;
          state_d   = SCAN;
          col_d     = {col_q[NCOL-2:0], col_q[NCOL-1]};
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= 4'b0001;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      scan_cnt_q  <= '0;
      cnt_q       <= '0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
      key_valid_q <= 1'b0;
      armed_q     <= 1'b0;
      clean_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      cnt_q       <= cnt_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      key_valid_q <= key_valid_d;
      armed_q     <= armed_d;
      clean_cnt_q <= clean_cnt_d;
    end
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;

  keypad_display_mux #(
    .MUX_DIV (MUX_DIV)
  ) u_mux (
    .clk       (int_osc),
    .rst       (reset),
    .digit_new (digit_new_q),
    .digit_old (digit_old_q),
    .hex_sel   (hex_sel),
    .an        (an)
  );

endmodule

`default_nettype wire
